// File: rtl/vtage_pkg.sv
// Shared types and constants for the VTAGE/LVP feedback path.
// Entry field widths live here; the top's width parameters must agree with them.
package vtage_pkg;

  localparam int VT_TAG_W  = 8;
  localparam int VT_CONF_W = 9;
  localparam int VT_U_W    = 2;

  localparam logic [15:0] P_LFSR_SEED = 16'hACE1;

  // Fibonacci taps 16/14/13/11 expressed as zero-based bit positions
  localparam int LFSR_TAP_A = 15;
  localparam int LFSR_TAP_B = 13;
  localparam int LFSR_TAP_C = 12;
  localparam int LFSR_TAP_D = 10;

  typedef struct packed {
    logic [VT_TAG_W-1:0]  tag;
    logic [31:0]          value;
    logic [VT_CONF_W-1:0] conf;
    logic [VT_U_W-1:0]    u;
  } vtage_entry_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[LFSR_TAP_A] ^ s[LFSR_TAP_B] ^ s[LFSR_TAP_C] ^ s[LFSR_TAP_D]};
  endfunction

endpackage

// File: rtl/vtage_fb_calc.sv
// Single-slot entry update: base entry + commit outcome -> entry to write back.
module vtage_fb_calc
  import vtage_pkg::*;
#(
  parameter bit P_LVP = 1'b0
) (
  input  vtage_entry_t        base_i,
  input  logic [VT_TAG_W-1:0] fb_tag_i,
  input  logic [31:0]         actual_i,
  input  logic                mispredict_i,
  input  logic                fpc_hit_i,
  output vtage_entry_t        entry_o
);

  logic conf_sat, u_sat;

  always_comb begin
    conf_sat = &base_i.conf;
    u_sat    = &base_i.u;
    entry_o       = base_i;
    entry_o.value = actual_i;
    if (mispredict_i) begin
      entry_o.conf = '0;
      // a worthless entry is handed to the new context instead of decaying further
      if (base_i.u == '0) entry_o.tag = fb_tag_i;
      else                entry_o.u   = base_i.u - VT_U_W'(1);
    end else begin
      if (fpc_hit_i && !conf_sat) entry_o.conf = base_i.conf + VT_CONF_W'(1);
      if (conf_sat && !u_sat)     entry_o.u    = base_i.u + VT_U_W'(1);
    end
    if (P_LVP) begin
      entry_o.tag = '0;
      entry_o.u   = '0;
    end
  end

endmodule

// File: rtl/vtage_fb_update.sv
// Feedback-side writer for one VTAGE/LVP bank: builds updated entries, drives
// the two table write ports one cycle later, and emits usefulness-aging pulses.
module vtage_fb_update
  import vtage_pkg::*;
#(
  parameter int P_BANK        = 0,
  parameter int P_NUM_PRED    = 2,
  parameter int P_NUM_ENTRIES = 256,
  parameter int P_CONF_WIDTH  = 8,
  parameter int P_TAG_WIDTH   = 8,
  parameter int P_U_WIDTH     = 2,
  parameter int P_FPC_BITS    = 3,
  parameter int P_AGE_LOG2    = 10,
  localparam int LP_INDEX_WIDTH = $clog2(P_NUM_ENTRIES)
) (
  input  logic                                       clk_i,
  input  logic                                       rst_ni,
  input  logic [P_NUM_PRED-1:0]                      fb_valid_i,
  input  logic [P_NUM_PRED-1:0][LP_INDEX_WIDTH-1:0]  fb_index_i,
  input  logic [P_NUM_PRED-1:0][P_TAG_WIDTH-1:0]     fb_tag_i,
  input  logic [P_NUM_PRED-1:0][P_CONF_WIDTH:0]      fb_conf_i,
  input  logic [P_NUM_PRED-1:0][P_U_WIDTH-1:0]       fb_useful_i,
  input  logic [P_NUM_PRED-1:0][31:0]                fb_actual_i,
  input  logic [P_NUM_PRED-1:0]                      fb_mispredict_i,
  output logic [P_NUM_PRED-1:0]                      wr_en_o,
  output logic [P_NUM_PRED-1:0][LP_INDEX_WIDTH-1:0]  wr_index_o,
  output vtage_entry_t [P_NUM_PRED-1:0]              wr_entry_o,
  output logic                                       age_pulse_o
);

  logic [15:0]                   lfsr_q;
  logic [P_AGE_LOG2-1:0]         age_q;
  logic [P_AGE_LOG2:0]           age_sum;
  vtage_entry_t [P_NUM_PRED-1:0] base, nxt;
  logic [P_NUM_PRED-1:0]         fpc_hit, en_nxt;

  // Base selection, FPC draw and same-cycle collision suppression per slot.
  // Ports are scanned in ascending order so the highest port's entry wins.
  always_comb begin
    for (int s = 0; s < P_NUM_PRED; s++) begin
      base[s] = '{tag: fb_tag_i[s], value: fb_actual_i[s],
                  conf: fb_conf_i[s], u: fb_useful_i[s]};
      for (int p = 0; p < P_NUM_PRED; p++)
        if (wr_en_o[p] && wr_index_o[p] == fb_index_i[s]) base[s] = wr_entry_o[p];
      fpc_hit[s] = lfsr_q[s*P_FPC_BITS +: P_FPC_BITS] == '0;
      en_nxt[s]  = fb_valid_i[s];
      for (int t = s + 1; t < P_NUM_PRED; t++)
        if (fb_valid_i[t] && fb_index_i[t] == fb_index_i[s]) en_nxt[s] = 1'b0;
    end
  end

  // One extra carry bit: several wraps in one cycle collapse into a single pulse.
  always_comb begin
    age_sum = {1'b0, age_q};
    for (int s = 0; s < P_NUM_PRED; s++)
      if (fb_valid_i[s]) age_sum = age_sum + (P_AGE_LOG2+1)'(1);
  end

  for (genvar g = 0; g < P_NUM_PRED; g++) begin : g_slot
    vtage_fb_calc #(.P_LVP(P_BANK == 0)) u_calc (
      .base_i       (base[g]),
      .fb_tag_i     (fb_tag_i[g]),
      .actual_i     (fb_actual_i[g]),
      .mispredict_i (fb_mispredict_i[g]),
      .fpc_hit_i    (fpc_hit[g]),
      .entry_o      (nxt[g])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_en_o     <= '0;
      wr_index_o  <= '0;
      wr_entry_o  <= '0;
      age_pulse_o <= 1'b0;
      lfsr_q      <= P_LFSR_SEED;
      age_q       <= '0;
    end else begin
      wr_en_o <= en_nxt;
      for (int s = 0; s < P_NUM_PRED; s++)
        if (en_nxt[s]) begin
          wr_index_o[s] <= fb_index_i[s];
          wr_entry_o[s] <= nxt[s];
        end
      if (|fb_valid_i) lfsr_q <= lfsr_next(lfsr_q);
      age_q       <= age_sum[P_AGE_LOG2-1:0];
      age_pulse_o <= age_sum[P_AGE_LOG2];
    end
  end

endmodule

// File: doc/vtage_fb_update.md
Name: vtage_fb_update

Overview:
- Feedback-side writer for one VTAGE/LVP bank. Consumes per-slot commit feedback: actual value, the original entry fields read at predict time, and the mispredict flag.
- Computes the updated table entry and drives the bank's two write ports (index, data, enable) with 1-cycle latency.
- Resolves same-index collisions, forwards in-flight writes, applies forward-probabilistic confidence increments, and generates a periodic usefulness-aging pulse.

Parameters:
- P_BANK, 0, bank number; 0 selects LVP mode (tag and u written as 0).
- P_NUM_PRED, 2, feedback slots (fixed at 2; the table has two write ports).
- P_NUM_ENTRIES, 256, table depth; LP_INDEX_WIDTH = $clog2(P_NUM_ENTRIES).
- P_CONF_WIDTH, 8, confidence field is P_CONF_WIDTH+1 bits.
- P_TAG_WIDTH, 8, tag width.
- P_U_WIDTH, 2, usefulness counter width.
- P_FPC_BITS, 3, confidence increments with probability 1/2^P_FPC_BITS.
- P_AGE_LOG2, 10, an aging pulse fires every 2^P_AGE_LOG2 valid feedback events.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous, active-low reset
- fb_valid_i  in  [P_NUM_PRED]  feedback valid per slot
- fb_index_i  in  [P_NUM_PRED][LP_INDEX_WIDTH]  entry index
- fb_tag_i  in  [P_NUM_PRED][P_TAG_WIDTH]  original tag
- fb_conf_i  in  [P_NUM_PRED][P_CONF_WIDTH+1]  original confidence
- fb_useful_i  in  [P_NUM_PRED][P_U_WIDTH]  original usefulness
- fb_actual_i  in  [P_NUM_PRED][32]  executed result
- fb_mispredict_i  in  [P_NUM_PRED]  prediction was wrong
- wr_en_o  out  [P_NUM_PRED]  table write enable
- wr_index_o  out  [P_NUM_PRED][LP_INDEX_WIDTH]  write address
- wr_entry_o  out  [P_NUM_PRED] vtage_entry_t  write data
- age_pulse_o  out  1  single-cycle usefulness-aging request

Behaviour:
- Reset (async, rst_ni=0): wr_en_o=0, wr_index_o=0, wr_entry_o=0, age_pulse_o=0, LFSR loaded with P_LFSR_SEED, age counter=0. Reset during activity drops any pending write; there is no replay.
- Latency: inputs are sampled at edge N; write outputs are valid for the cycle after edge N. The block is always ready and has no backpressure.
- Base selection per slot: if the slot's index equals an index written in the previous cycle (wr_en_o=1 on either port), the base conf/u/tag come from the last wr_entry_o for that index (port 1 takes priority). Otherwise the base comes from fb_* inputs.
- Correct prediction (mispredict=0):
  - value is unchanged (= actual).
  - conf increments, saturating at all-ones, only when LFSR[P_FPC_BITS-1:0]==0. Slot 1 uses LFSR[2*P_FPC_BITS-1:P_FPC_BITS].
  - u increments, saturating, when base conf is already saturated.
- Mispredict:
  - value := actual, conf := 0.
  - If base u==0, tag := fb_tag_i (reallocation); otherwise u decrements by 1.
- P_BANK==0: tag and u are always written as 0.
- Collision: both slots valid with equal index in the same cycle → slot 1 (younger) writes, and slot 0's write enable is suppressed.
- LFSR: 16-bit Fibonacci, taps 16/14/13/11. Advances every cycle in which any fb_valid_i is set.
- Aging counter: P_AGE_LOG2 bits, adds popcount(fb_valid_i) with wrap. age_pulse_o=1 for one cycle after any wrap; two wraps in one cycle still give a single pulse.

Decomposition:
- Shared package vtage_pkg holds:
  - vtage_entry_t {tag, value[31:0], conf, u}
  - P_LFSR_SEED = 16'hACE1
  - LFSR tap constants
- Sub-module vtage_fb_calc: combinational single-slot update (base, actual, mispredict, fpc_hit → new entry). It is instantiated P_NUM_PRED times.

Test Plan:
- Reset mid-stream: assert rst_ni=0 while fb_valid_i=2'b11 → wr_en_o=0 in the same cycle and the next; age_pulse_o=0.
- Slot 0 mispredict, idx 5, u=2, conf=200, actual=0xDEAD → next cycle wr_en_o[0]=1, index 5, value 0xDEAD, conf 0, u 1, tag unchanged.
- Slot 0 mispredict, u=0, tag 0x3C → the written tag is 0x3C and u=0. With P_BANK=0 the written tag is 0.
- Both slots idx 7, same cycle → wr_en_o=2'b10 and the slot 1 entry is written.
- Back-to-back correct feedback on idx 9 with fb_conf_i=10 twice, with forced FPC hits → written conf 11 then 12 (forwarded base, not 11 twice).
- Run 1024 single-slot feedbacks with P_AGE_LOG2=10 → exactly one age_pulse_o, one cycle after the 1024th. Conf at 511 stays 511, and u increments.
